// File: rtl/def_pkg.sv
// Shared AES datapath types and small helpers used by the request arbiter.
package def_pkg;

  localparam int BLOCK_W = 128;

  typedef logic [BLOCK_W-1:0] block;

  // Successor of v in a ring of n slots.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/aes_rsp_fifo.sv
// Response FIFO with registered storage and a first-word-fall-through head.
module aes_rsp_fifo
  import def_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 130
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  // A pop on a full FIFO frees the slot that the simultaneous push reuses.
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/aes_req_arbiter.sv
// Round-robin front-end sharing one pipelined, non-stallable AES core between
// N_REQ requesters; credits bound in-flight blocks to the response FIFO depth.
module aes_req_arbiter
  import def_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int LATENCY    = 41,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [N_REQ-1:0]              i_req_valid,
  input  logic [N_REQ*BLOCK_W-1:0]      i_req_state,
  input  logic [N_REQ*BLOCK_W-1:0]      i_req_key,
  output logic [N_REQ-1:0]              o_req_ready,
  output logic                          o_core_tx_en,
  output logic [BLOCK_W-1:0]            o_core_state,
  output logic [BLOCK_W-1:0]            o_core_key,
  input  logic                          i_core_tx_en,
  input  logic [BLOCK_W-1:0]            i_core_state,
  output logic                          o_rsp_valid,
  output logic [$clog2(N_REQ)-1:0]      o_rsp_id,
  output logic [BLOCK_W-1:0]            o_rsp_state,
  input  logic                          i_rsp_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_outstanding,
  output logic                          o_err
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [ID_W-1:0] id;
    block            state;
  } rsp_entry_t;

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_any;
  logic             credit_ok;
  block             gnt_state;
  block             gnt_key;
  logic [ID_W-1:0]  core_id_q;
  logic             tag_v  [LATENCY];
  logic [ID_W-1:0]  tag_id [LATENCY];
  logic             push;
  logic             pop;
  rsp_entry_t       push_entry;
  rsp_entry_t       head_entry;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             unused_fifo_status;

  assign credit_ok = (o_outstanding < CNT_W'(FIFO_DEPTH));

  // Search from rr_ptr upward with wrap; reset gating keeps ready low while held.
  always_comb begin
    gnt_any     = 1'b0;
    gnt_id      = '0;
    o_req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      int              idx;
      logic [ID_W-1:0] idx_b;
      idx = int'(rr_ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_b = ID_W'(idx);
      if (!gnt_any && i_req_valid[idx_b] && credit_ok && reset_n) begin
        gnt_any = 1'b1;
        gnt_id  = idx_b;
      end
    end
    if (gnt_any) o_req_ready[gnt_id] = 1'b1;
  end

  always_comb begin
    gnt_state = '0;
    gnt_key   = '0;
    for (int r = 0; r < N_REQ; r++) begin
      if (gnt_any && gnt_id == ID_W'(r)) begin
        gnt_state = i_req_state[r*BLOCK_W +: BLOCK_W];
        gnt_key   = i_req_key[r*BLOCK_W +: BLOCK_W];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr       <= '0;
      o_core_tx_en <= 1'b0;
      o_core_state <= '0;
      o_core_key   <= '0;
      core_id_q    <= '0;
    end else begin
      if (gnt_any) rr_ptr <= ID_W'(wrap_inc(int'(gnt_id), N_REQ));
      o_core_tx_en <= gnt_any;
      o_core_state <= gnt_state;
      o_core_key   <= gnt_key;
      core_id_q    <= gnt_any ? gnt_id : '0;
    end
  end

  // Tag line: stage 0 follows the issue register, last stage meets the core output.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        tag_v[i]  <= 1'b0;
        tag_id[i] <= '0;
      end
    end else begin
      tag_v[0]  <= o_core_tx_en;
      tag_id[0] <= core_id_q;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign push             = i_core_tx_en & tag_v[LATENCY-1];
  assign push_entry.id    = tag_id[LATENCY-1];
  assign push_entry.state = i_core_state;
  assign pop              = o_rsp_valid & i_rsp_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      o_err         <= 1'b0;
      o_outstanding <= '0;
    end else begin
      if (i_core_tx_en != tag_v[LATENCY-1]) o_err <= 1'b1;
      if (gnt_any && !pop)      o_outstanding <= o_outstanding + CNT_W'(1);
      else if (!gnt_any && pop) o_outstanding <= o_outstanding - CNT_W'(1);
    end
  end

  aes_rsp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(rsp_entry_t))
  ) u_rsp_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign unused_fifo_status = ^{fifo_full, fifo_count};

  assign o_rsp_valid = ~fifo_empty;
  assign o_rsp_id    = o_rsp_valid ? head_entry.id : '0;
  assign o_rsp_state = o_rsp_valid ? head_entry.state : '0;

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Directed bench for aes_req_arbiter with a behavioural fixed-latency core model.
module tb_aes_req_arbiter;
  import def_pkg::*;

  localparam int N_REQ      = 4;
  localparam int LATENCY    = 41;
  localparam int FIFO_DEPTH = 8;

  localparam block PT  = 128'h00112233445566778899aabbccddeeff;
  localparam block KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam block CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic                     clock;
  logic                     reset_n;
  logic [N_REQ-1:0]         i_req_valid;
  logic [N_REQ*128-1:0]     i_req_state;
  logic [N_REQ*128-1:0]     i_req_key;
  logic [N_REQ-1:0]         o_req_ready;
  logic                     o_core_tx_en;
  logic [127:0]             o_core_state;
  logic [127:0]             o_core_key;
  logic                     i_core_tx_en;
  logic [127:0]             i_core_state;
  logic                     o_rsp_valid;
  logic [1:0]               o_rsp_id;
  logic [127:0]             o_rsp_state;
  logic                     i_rsp_ready;
  logic [3:0]               o_outstanding;
  logic                     o_err;

  logic                     inj;
  logic                     pipe_v [LATENCY];
  block                     pipe_d [LATENCY];

  int n_assert;
  int n_fail;

  aes_req_arbiter #(
    .N_REQ      (N_REQ),
    .LATENCY    (LATENCY),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .i_req_valid   (i_req_valid),
    .i_req_state   (i_req_state),
    .i_req_key     (i_req_key),
    .o_req_ready   (o_req_ready),
    .o_core_tx_en  (o_core_tx_en),
    .o_core_state  (o_core_state),
    .o_core_key    (o_core_key),
    .i_core_tx_en  (i_core_tx_en),
    .i_core_state  (i_core_state),
    .o_rsp_valid   (o_rsp_valid),
    .o_rsp_id      (o_rsp_id),
    .o_rsp_state   (o_rsp_state),
    .i_rsp_ready   (i_rsp_ready),
    .o_outstanding (o_outstanding),
    .o_err         (o_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stand-in cipher: the known test vector maps to its AES-128 ciphertext.
  function automatic block enc(input block s, input block k);
    if (s == PT && k == KEY) return CT;
    return s ^ {k[63:0], k[127:64]} ^ {4{32'h5a5ac3c3}};
  endfunction

  function automatic block pt_of(input int r);
    return {4{32'hc0de0000 | 32'(r)}};
  endfunction

  function automatic block key_of(input int r);
    return {4{32'hbeef0000 | 32'(r)}};
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_d[i] <= '0;
      end
    end else begin
      pipe_v[0] <= o_core_tx_en;
      pipe_d[0] <= enc(o_core_state, o_core_key);
      for (int i = 1; i < LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign i_core_tx_en = pipe_v[LATENCY-1] | inj;
  assign i_core_state = pipe_d[LATENCY-1];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   g;
    int   cyc;
    logic seen_rsp;
    logic seen_err;
    logic seen_tx;

    n_assert    = 0;
    n_fail      = 0;
    reset_n     = 1'b0;
    inj         = 1'b0;
    i_req_valid = '0;
    i_rsp_ready = 1'b0;
    for (int r = 0; r < N_REQ; r++) begin
      i_req_state[r*128 +: 128] = pt_of(r);
      i_req_key[r*128 +: 128]   = key_of(r);
    end

    // Reset state
    repeat (3) step();
    chk("rst_ready",       128'(o_req_ready),   128'h0);
    chk("rst_core_tx_en",  128'(o_core_tx_en),  128'h0);
    chk("rst_core_state",  o_core_state,        128'h0);
    chk("rst_rsp_valid",   128'(o_rsp_valid),   128'h0);
    chk("rst_outstanding", 128'(o_outstanding), 128'h0);
    chk("rst_err",         128'(o_err),         128'h0);
    reset_n = 1'b1;
    step();

    // Single request from requester 2 with the known test vector
    i_rsp_ready = 1'b1;
    i_req_state[2*128 +: 128] = PT;
    i_req_key[2*128 +: 128]   = KEY;
    i_req_valid = 4'b0100;
    #1;
    chk("single_ready", 128'(o_req_ready), 128'h4);
    step();
    i_req_valid = '0;
    chk("single_tx_en",       128'(o_core_tx_en),  128'h1);
    chk("single_core_state",  o_core_state,        PT);
    chk("single_core_key",    o_core_key,          KEY);
    chk("single_outstanding", 128'(o_outstanding), 128'h1);
    repeat (LATENCY) step();
    chk("single_rsp_early", 128'(o_rsp_valid), 128'h0);
    step();
    chk("single_rsp_valid", 128'(o_rsp_valid), 128'h1);
    chk("single_rsp_id",    128'(o_rsp_id),    128'h2);
    chk("single_rsp_state", o_rsp_state,       CT);
    step();
    chk("single_popped",      128'(o_rsp_valid),   128'h0);
    chk("single_out_drained", 128'(o_outstanding), 128'h0);
    chk("single_err",         128'(o_err),         128'h0);
    i_req_state[2*128 +: 128] = pt_of(2);
    i_req_key[2*128 +: 128]   = key_of(2);

    // Fairness and credit exhaustion: pointer sits at 3 after the grant to 2
    i_rsp_ready = 1'b0;
    i_req_valid = 4'b1111;
    #1;
    g = 3;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      chk($sformatf("rr_ready_%0d", k), 128'(o_req_ready), 128'(4'b0001 << g));
      step();
      chk($sformatf("rr_issue_%0d", k), o_core_state, pt_of(g));
      g = (g + 1) % N_REQ;
    end
    chk("credit_out_full", 128'(o_outstanding), 128'h8);
    chk("credit_ready_0",  128'(o_req_ready),   128'h0);
    repeat (LATENCY + 1) step();
    chk("fill_ready_0",  128'(o_req_ready),   128'h0);
    chk("fill_out",      128'(o_outstanding), 128'h8);
    chk("fill_valid",    128'(o_rsp_valid),   128'h1);
    chk("fill_err",      128'(o_err),         128'h0);

    // Drain in issue order; issue resumes the cycle after the first pop
    chk("drain_id_0",    128'(o_rsp_id), 128'h3);
    chk("drain_state_0", o_rsp_state,    enc(pt_of(3), key_of(3)));
    i_rsp_ready = 1'b1;
    step();
    chk("resume_out",   128'(o_outstanding), 128'h7);
    chk("resume_ready", 128'(o_req_ready),   128'h8);
    chk("drain_id_1",    128'(o_rsp_id), 128'h0);
    chk("drain_state_1", o_rsp_state,    enc(pt_of(0), key_of(0)));
    step();
    i_req_valid = '0;
    chk("hs_pop_out",   128'(o_outstanding), 128'h7);
    chk("resume_tx_en", 128'(o_core_tx_en),  128'h1);
    chk("resume_state", o_core_state,        pt_of(3));
    for (int k = 2; k < FIFO_DEPTH; k++) begin
      g = (3 + k) % N_REQ;
      chk($sformatf("drain_id_%0d", k),    128'(o_rsp_id), 128'(g));
      chk($sformatf("drain_state_%0d", k), o_rsp_state,    enc(pt_of(g), key_of(g)));
      step();
    end
    chk("drain_empty", 128'(o_rsp_valid),   128'h0);
    chk("drain_out",   128'(o_outstanding), 128'h1);
    cyc = 0;
    while (!o_rsp_valid && cyc < 100) begin
      step();
      cyc++;
    end
    chk("late_wait",  128'(cyc),      128'(LATENCY - 5));
    chk("late_id",    128'(o_rsp_id), 128'h3);
    chk("late_state", o_rsp_state,    enc(pt_of(3), key_of(3)));
    step();
    chk("late_out", 128'(o_outstanding), 128'h0);

    // Error injection: strobe with no tag in flight
    inj = 1'b1;
    step();
    inj = 1'b0;
    chk("err_set",      128'(o_err),         128'h1);
    chk("err_no_push",  128'(o_rsp_valid),   128'h0);
    chk("err_out",      128'(o_outstanding), 128'h0);
    repeat (5) step();
    chk("err_sticky",   128'(o_err),         128'h1);

    // Mid-operation reset with 5 blocks in flight
    i_req_valid = 4'b1111;
    repeat (5) step();
    chk("mid_out", 128'(o_outstanding), 128'h5);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready",     128'(o_req_ready),   128'h0);
    chk("mid_rst_tx_en",     128'(o_core_tx_en),  128'h0);
    chk("mid_rst_core_key",  o_core_key,          128'h0);
    chk("mid_rst_out",       128'(o_outstanding), 128'h0);
    chk("mid_rst_err",       128'(o_err),         128'h0);
    chk("mid_rst_rsp_valid", 128'(o_rsp_valid),   128'h0);
    chk("mid_rst_rsp_state", o_rsp_state,         128'h0);
    repeat (2) step();
    reset_n = 1'b1;
    #1;
    chk("post_rst_ready", 128'(o_req_ready), 128'h1);
    i_req_valid = '0;
    seen_rsp = 1'b0;
    seen_err = 1'b0;
    seen_tx  = 1'b0;
    repeat (LATENCY + 10) begin
      step();
      seen_rsp = seen_rsp | o_rsp_valid;
      seen_err = seen_err | o_err;
      seen_tx  = seen_tx | o_core_tx_en;
    end
    chk("post_rst_no_rsp", 128'(seen_rsp), 128'h0);
    chk("post_rst_no_err", 128'(seen_err), 128'h0);
    chk("post_rst_no_tx",  128'(seen_tx),  128'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
